// File: rtl/zeptron_pkg.sv
// Shared core definitions: machine width, canonical NOP and the fetch buffer entry.
package zeptron_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head entry is read combinationally.
module fetch_fifo
  import zeptron_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) assert (!(push_i && full_o && !do_pop));
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem requests, response buffering and redirect handling.
// Optional misaligned-redirect fault entry is built when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_stage
  import zeptron_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, last_pc_q, target;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, fifo_cnt;
  logic            fault_q;
  logic            req_fire, rsp_acc, push, pop, fifo_empty, fifo_full_unused;
  fetch_entry_t    head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_d;
  assign target  = redirect_pc;
  assign fault_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_q;
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`else
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc[1:0];
  assign target        = {redirect_pc[XLEN-1:2], 2'b00};
  assign fault_q       = 1'b0;
`endif

  // Requests in flight plus buffered entries never exceed the buffer, so every response has a slot.
  assign imem_req_valid = !rst && !redirect_valid && !fault_q &&
                          (({1'b0, out_q} + {1'b0, fifo_cnt}) < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding belongs to a request issued before reset.
  assign rsp_acc        = imem_rsp_valid && (out_q != '0);
  assign push_entry     = '{instr: imem_rsp_data, pc: rsp_pc_q};

  assign if_valid = (!fifo_empty || fault_q) && !redirect_valid;
  assign pop      = if_valid && if_ready && !fault_q;
  assign if_instr = (fault_q || fifo_empty) ? NOP_INSTR : head.instr;
  assign if_pc    = fault_q ? pc_q : (fifo_empty ? last_pc_q : head.pc);
  assign if_fault = fault_q;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CW'(req_fire) - CW'(rsp_acc);
    drop_d   = drop_q;
    push     = 1'b0;
    if (redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      // Everything still in flight is stale now, including responses already marked for dropping.
      drop_d   = out_q - CW'(rsp_acc);
    end else begin
      if (req_fire) pc_d = next_word_pc(pc_q);
      if (rsp_acc) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          push     = 1'b1;
          rsp_pc_d = next_word_pc(rsp_pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      last_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      if (!fifo_empty) last_pc_q <= head.pc;
    end
  end

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_cnt),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int lat = 1;
  int nreq = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pq[$];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Handshake seen mid-cycle completes at the next edge; its response shows up lat cycles later.
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      pq.push_back('{imem_req_addr, cyc + lat});
      nreq++;
    end
  end

  always @(posedge clk) begin
    pend_t p;
    cyc++;
    #1;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      p = pq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(p.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #2;
  endtask

  task automatic do_reset(input int n, input string nm);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk1({nm, "_rst_valid"}, if_valid, 1'b0);
    chk1({nm, "_rst_reqv"}, imem_req_valid, 1'b0);
    chk({nm, "_rst_instr"}, if_instr, NOP);
    chk({nm, "_rst_pc"}, if_pc, 32'h0);
    chk1({nm, "_rst_fault"}, if_fault, 1'b0);
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] epc);
    int n = 0;
    while (!if_valid && n < 30) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    chk1({nm, "_timeout"}, if_valid, 1'b1);
    chk({nm, "_pc"}, if_pc, epc);
    chk({nm, "_instr"}, if_instr, mem_word(epc));
  endtask

  typedef struct {
    logic        rdy;
    logic        exp_v;
    logic        exp_rq;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  initial begin
    vec_t tv[7];
    int   base;

    tv[0] = '{1'b1, 1'b0, 1'b1, 32'h0, NOP};
    tv[1] = '{1'b1, 1'b0, 1'b1, 32'h0, NOP};
    tv[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'hC0DE_0000};
    tv[3] = '{1'b1, 1'b1, 1'b1, 32'h4, 32'hC0DE_0004};
    tv[4] = '{1'b1, 1'b0, 1'b1, 32'h4, NOP};
    tv[5] = '{1'b1, 1'b1, 1'b0, 32'h8, 32'hC0DE_0008};
    tv[6] = '{1'b1, 1'b1, 1'b1, 32'hC, 32'hC0DE_000C};

    // 1: streaming with single-cycle memory
    lat = 1;
    do_reset(5, "t1");
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 32'h0, tv[i].rdy);
      chk1($sformatf("t1_c%0d_valid", i + 1), if_valid, tv[i].exp_v);
      chk1($sformatf("t1_c%0d_reqv", i + 1), imem_req_valid, tv[i].exp_rq);
      chk($sformatf("t1_c%0d_pc", i + 1), if_pc, tv[i].exp_pc);
      chk($sformatf("t1_c%0d_instr", i + 1), if_instr, tv[i].exp_instr);
    end

    // 2: decode stalls, buffer fills, then drains in order
    do_reset(5, "t2");
    base = nreq;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_req_count", 32'(nreq - base), 32'd2);
    chk1("t2_full_reqv", imem_req_valid, 1'b0);
    chk1("t2_full_valid", if_valid, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_head0_pc", if_pc, 32'h0);
    chk("t2_head0_instr", if_instr, mem_word(32'h0));
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("t2_head1_valid", if_valid, 1'b1);
    chk("t2_head1_pc", if_pc, 32'h4);
    chk("t2_head1_instr", if_instr, mem_word(32'h4));

    // 3: redirect with two slow responses in flight
    lat = 3;
    do_reset(5, "t3");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    chk1("t3_redir_reqv", imem_req_valid, 1'b0);
    chk1("t3_redir_valid", if_valid, 1'b0);
    wait_valid("t3", 32'h100);

    // 4: redirect coincides with a response and a ready decode
    lat = 1;
    do_reset(5, "t4");
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    chk1("t4_redir_valid", if_valid, 1'b0);
    chk1("t4_redir_reqv", imem_req_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("t4_after_valid", if_valid, 1'b0);
    chk1("t4_after_reqv", imem_req_valid, 1'b1);
    chk("t4_after_addr", imem_req_addr, 32'h40);
    wait_valid("t4", 32'h40);

    // 5: reset while two requests are outstanding; one response lands after reset
    lat = 3;
    do_reset(5, "t5pre");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset(2, "t5");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("t5_restart_reqv", imem_req_valid, 1'b1);
    chk("t5_restart_addr", imem_req_addr, 32'h0);
    wait_valid("t5", 32'h0);

    // 6: misaligned redirect target
    lat = 1;
    do_reset(5, "t6");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h102, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("t6_fault", if_fault, 1'b1);
    chk1("t6_fault_valid", if_valid, 1'b1);
    chk("t6_fault_pc", if_pc, 32'h102);
    chk("t6_fault_instr", if_instr, NOP);
    chk1("t6_fault_reqv", imem_req_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("t6_persist_fault", if_fault, 1'b1);
    chk1("t6_persist_valid", if_valid, 1'b1);
    chk1("t6_persist_reqv", imem_req_valid, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("t6_clear_fault", if_fault, 1'b0);
    chk1("t6_clear_reqv", imem_req_valid, 1'b1);
    chk("t6_clear_addr", imem_req_addr, 32'h200);
    wait_valid("t6b", 32'h200);
`else
    chk1("t6_nofault", if_fault, 1'b0);
    chk1("t6_reqv", imem_req_valid, 1'b1);
    chk("t6_addr", imem_req_addr, 32'h100);
    wait_valid("t6", 32'h100);
    chk1("t6_nofault_out", if_fault, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
